// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to DMA_REG stalls the CPU and copies 256 bytes {page,00..FF} to OAM_PORT.
// Optional macro OAM_DMA_ALIGN_EN: an even HALT tick inserts one ALIGN tick before the first read.
module oam_dma #(
   parameter logic [15:0] DMA_REG  = 16'h4014,
   parameter logic [15:0] OAM_PORT = 16'h2004
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_d,
   input  logic        cpu_r,
   input  logic        cpu_w,
   output logic        cpu_ce,
   output logic [15:0] bus_a,
   output logic [7:0]  bus_d,
   output logic        bus_r,
   output logic        bus_w,
   input  logic [7:0]  bus_i,
   output logic        busy
);

`ifdef OAM_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_idx, r_page, r_latch;
   logic        r_parity;
   logic        w_trigger;

   assign w_trigger = (r_state == S_IDLE) & cpu_w & (cpu_a == DMA_REG);

   always_ff @(posedge clock) begin
      if (reset)   r_state <= S_IDLE;
      else if (ce) r_state <= w_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_idx    <= 8'h00;
         r_page   <= 8'h00;
         r_latch  <= 8'h00;
         r_parity <= 1'b0;
      end else if (ce) begin
         r_parity <= ~r_parity;
         if (w_trigger) begin
            r_page <= cpu_d;
            r_idx  <= 8'h00;
         end
         if (r_state == S_READ)  r_latch <= bus_i;
         if (r_state == S_WRITE) r_idx   <= r_idx + 8'd1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_trigger) w_next = S_HALT;
         // parity is the pre-toggle value of this HALT tick
         S_HALT:  w_next = (r_parity || !ALIGN_EN) ? S_READ : S_ALIGN;
         S_ALIGN: w_next = S_READ;
         S_READ:  w_next = S_WRITE;
         S_WRITE: w_next = (r_idx == 8'hFF) ? S_IDLE : S_READ;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus_a = {r_page, r_idx};
      bus_d = 8'h00;
      bus_r = 1'b0;
      bus_w = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus_a = cpu_a;
            bus_d = cpu_d;
            bus_r = cpu_r;
            bus_w = cpu_w;
         end
         S_READ:  bus_r = 1'b1;
         S_WRITE: begin
            bus_a = OAM_PORT;
            bus_d = r_latch;
            bus_w = 1'b1;
         end
         default: ;
      endcase
   end

   assign cpu_ce = ce & (r_state == S_IDLE);
   assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: pass-through, odd/even HALT timing, ce division, abort, non-trigger writes.
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b1;
   logic [15:0] cpu_a = 16'h0000;
   logic [7:0]  cpu_d = 8'h00;
   logic        cpu_r = 1'b0;
   logic        cpu_w = 1'b0;
   logic        cpu_ce, bus_r, bus_w, busy;
   logic [15:0] bus_a;
   logic [7:0]  bus_d, bus_i;

   int n_chk = 0;
   int n_fail = 0;
   bit par = 1'b0;   // expected value of the DUT parity register

   function automatic logic [7:0] mem(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
   endfunction

   assign bus_i = mem(bus_a);

   always #5 clock = ~clock;

   oam_dma dut (
      .clock(clock), .reset(reset), .ce(ce),
      .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_r(cpu_r), .cpu_w(cpu_w),
      .cpu_ce(cpu_ce),
      .bus_a(bus_a), .bus_d(bus_d), .bus_r(bus_r), .bus_w(bus_w),
      .bus_i(bus_i), .busy(busy)
   );

   // Trigger a transfer so that the HALT tick sees parity hpar, then follow every phase.
   // abort_w > 0 returns right after that many WRITE ticks.
   task automatic run_dma(input logic [7:0] pg, input int div, input bit hpar, input int abort_w);
      bit          align;
      int          kind, nw, np;
      logic [15:0] ra;
      logic [7:0]  exp_d;
      align = ALIGN_EN && !hpar;
      np = 1 + int'(align) + 512;
      ce = 1'b1; cpu_w = 1'b0; cpu_r = 1'b0; cpu_a = 16'h0000;
      if (par == hpar) begin
         @(posedge clock); #1; par = ~par;
      end
      cpu_a = 16'h4014; cpu_d = pg; cpu_w = 1'b1;
      @(negedge clock); n_chk++;
      if ({busy, cpu_ce, bus_w, bus_a} !== {3'b011, 16'h4014}) begin
         n_fail++;
         $display("FAIL trigger_tick pg=%h: got busy=%b cpu_ce=%b bus_w=%b bus_a=%h, want 0 1 1 4014",
                  pg, busy, cpu_ce, bus_w, bus_a);
      end
      @(posedge clock); #1; par = ~par;
      cpu_d = 8'h99; cpu_r = 1'b1;   // stalled CPU keeps writing DMA_REG; must be ignored
      nw = 0;
      for (int p = 0; p < np; p++) begin
         kind = (p < 1 + int'(align)) ? 0 : (((p - 1 - int'(align)) % 2 == 0) ? 1 : 2);
         ra = 16'h0000;
         if (kind != 0) ra = {pg, 8'((p - 1 - int'(align)) / 2)};
         exp_d = mem(ra);
         if (kind == 2 && nw == 255) begin
            cpu_w = 1'b0; cpu_r = 1'b1; cpu_a = 16'h1234;
         end
         for (int k = 0; k < div; k++) begin
            ce = (k == div - 1);
            @(negedge clock); n_chk++;
            if (kind == 0 && {busy, cpu_ce, bus_r, bus_w} !== 4'b1000) begin
               n_fail++;
               $display("FAIL halt_align pg=%h p=%0d: got busy=%b cpu_ce=%b r=%b w=%b, want 1 0 0 0",
                        pg, p, busy, cpu_ce, bus_r, bus_w);
            end
            if (kind == 1 && {busy, cpu_ce, bus_r, bus_w, bus_a} !== {4'b1010, ra}) begin
               n_fail++;
               $display("FAIL read pg=%h p=%0d: got busy=%b cpu_ce=%b r=%b w=%b a=%h, want 1 0 1 0 %h",
                        pg, p, busy, cpu_ce, bus_r, bus_w, bus_a, ra);
            end
            if (kind == 2 && {busy, cpu_ce, bus_r, bus_w, bus_a, bus_d} !== {4'b1001, 16'h2004, exp_d}) begin
               n_fail++;
               $display("FAIL write pg=%h p=%0d: got busy=%b cpu_ce=%b r=%b w=%b a=%h d=%h, want 1 0 0 1 2004 %h",
                        pg, p, busy, cpu_ce, bus_r, bus_w, bus_a, bus_d, exp_d);
            end
            @(posedge clock); #1;
            if (ce) par = ~par;
         end
         if (kind == 2) begin
            nw++;
            if (nw == abort_w) return;
         end
      end
      ce = 1'b1;
      @(negedge clock); n_chk++;
      if ({busy, cpu_ce, bus_r, bus_w, bus_a} !== {4'b0110, 16'h1234}) begin
         n_fail++;
         $display("FAIL end_idle pg=%h: got busy=%b cpu_ce=%b r=%b w=%b a=%h, want 0 1 1 0 1234",
                  pg, busy, cpu_ce, bus_r, bus_w, bus_a);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; ce = 1'b1; cpu_a = 16'h1234; cpu_r = 1'b1; cpu_w = 1'b0;
      repeat (2) @(posedge clock);
      #1; reset = 1'b0; par = 1'b0;
      @(negedge clock); n_chk++;
      if ({busy, cpu_ce, bus_r, bus_w, bus_a} !== {4'b0110, 16'h1234}) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b cpu_ce=%b r=%b w=%b a=%h, want 0 1 1 0 1234",
                  busy, cpu_ce, bus_r, bus_w, bus_a);
      end
      @(posedge clock); #1; par = ~par;
      ce = 1'b0;
      @(negedge clock); n_chk++;
      if (cpu_ce !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ce_gate: got cpu_ce=%b, want 0", cpu_ce);
      end
      @(posedge clock); #1; ce = 1'b1;
   endtask

   task automatic test_odd;
      run_dma(8'h02, 1, 1'b1, 0);
   endtask

   task automatic test_even;
      run_dma(8'h05, 1, 1'b0, 0);
   endtask

   task automatic test_ce_div;
      run_dma(8'h02, 3, 1'b1, 0);
      run_dma(8'h0A, 3, 1'b0, 0);
   endtask

   task automatic test_abort;
      run_dma(8'h03, 1, 1'b1, 100);
      cpu_w = 1'b0; cpu_r = 1'b1; cpu_a = 16'h1234; ce = 1'b1;
      reset = 1'b1;
      @(posedge clock); #1; reset = 1'b0; par = 1'b0;
      @(negedge clock); n_chk++;
      if ({busy, cpu_ce, bus_r, bus_w, bus_a} !== {4'b0110, 16'h1234}) begin
         n_fail++;
         $display("FAIL abort_idle: got busy=%b cpu_ce=%b r=%b w=%b a=%h, want 0 1 1 0 1234",
                  busy, cpu_ce, bus_r, bus_w, bus_a);
      end
      @(posedge clock); #1; par = ~par;
      run_dma(8'h07, 1, 1'b1, 0);
   endtask

   task automatic test_no_trigger;
      ce = 1'b1; cpu_a = 16'h4015; cpu_d = 8'h02; cpu_w = 1'b1; cpu_r = 1'b0;
      @(negedge clock); n_chk++;
      if ({busy, cpu_ce, bus_r, bus_w, bus_a, bus_d} !== {4'b0101, 16'h4015, 8'h02}) begin
         n_fail++;
         $display("FAIL write_4015: got busy=%b cpu_ce=%b r=%b w=%b a=%h d=%h, want 0 1 0 1 4015 02",
                  busy, cpu_ce, bus_r, bus_w, bus_a, bus_d);
      end
      @(posedge clock); #1; par = ~par;
      cpu_w = 1'b0; cpu_r = 1'b1; cpu_a = 16'h4014;
      @(negedge clock); n_chk++;
      if ({busy, cpu_ce, bus_r, bus_w, bus_a} !== {4'b0110, 16'h4014}) begin
         n_fail++;
         $display("FAIL read_4014: got busy=%b cpu_ce=%b r=%b w=%b a=%h, want 0 1 1 0 4014",
                  busy, cpu_ce, bus_r, bus_w, bus_a);
      end
      @(posedge clock); #1; par = ~par;
      cpu_r = 1'b0;
      @(negedge clock); n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL no_trigger_busy: got busy=%b, want 0", busy);
      end
      @(posedge clock); #1; par = ~par;
   endtask

   initial begin
      #1;
      test_reset;
      test_odd;
      test_even;
      test_ce_div;
      test_abort;
      test_no_trigger;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
